// File: rtl/eth_rx.sv
// RMII Ethernet receiver. It detects the preamble and SFD, assembles dibits into bytes and checks
// the CRC-32 residue, the frame length and the alignment. It latches the header plus 46 payload bytes.
package Types;
  typedef struct packed {
    logic [47:0]  dest_mac;
    logic [47:0]  src_mac;
    logic [15:0]  ethertype;
    logic [367:0] payload;
  } st_eth_packet;
endpackage

module eth_rx #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic               eth_clk,
  input  logic               rst_in,
  input  logic               eth_crsdv,
  input  logic [1:0]         eth_rxd,
  output Types::st_eth_packet eth_packet,
  output logic               rx_valid,
  output logic               rx_err,
  output logic [1:0]         rx_err_code,
  output logic               rx_busy
);

  localparam int                CNT_W       = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(MAX_FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0]  CNT_MIN     = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [31:0]       CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]       CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  // Reflected CRC-32 advanced by one dibit, bit 0 first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          dibit_cnt_q, dibit_cnt_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [5:0]          byte_sr_q, byte_sr_d;
  logic [31:0]         crc_q, crc_d;
  logic [479:0]        shadow_q, shadow_d;
  Types::st_eth_packet pkt_q, pkt_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_err_q, rx_err_d;
  logic [1:0]          rx_err_code_q, rx_err_code_d;
  logic                rx_busy_q, rx_busy_d;
  logic [7:0]          byte_done;

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d       = state_q;
    dibit_cnt_d   = dibit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_sr_d     = byte_sr_q;
    crc_d         = crc_q;
    shadow_d      = shadow_q;
    pkt_d         = pkt_q;
    rx_valid_d    = 1'b0;
    rx_err_d      = 1'b0;
    rx_err_code_d = 2'd0;
    byte_done     = {eth_rxd, byte_sr_q};

    case (state_q)
      ST_IDLE: begin
        if (eth_crsdv) state_d = ST_PREAMBLE;
        else           state_d = ST_IDLE;
      end
      ST_PREAMBLE: begin
        if (!eth_crsdv) begin
          state_d = ST_IDLE;
        end else begin
          case (eth_rxd)
            2'b00, 2'b01: state_d = ST_PREAMBLE;
            2'b11: begin
              state_d     = ST_DATA;
              dibit_cnt_d = 2'd0;
              byte_cnt_d  = '0;
              byte_sr_d   = 6'd0;
              crc_d       = CRC_INIT;
            end
            default: state_d = ST_DROP;
          endcase
        end
      end
      ST_DATA: begin
        if (eth_crsdv) begin
          crc_d       = crc32_dibit(crc_q, eth_rxd);
          byte_sr_d   = byte_done[7:2];
          dibit_cnt_d = dibit_cnt_q + 2'd1;
          if (dibit_cnt_q == 2'd3) begin
            // Only the first 60 bytes land in the shadow packet, byte 0 at the top.
            for (int i = 0; i < 60; i++) begin
              if (byte_cnt_q == CNT_W'(i)) shadow_d[(59 - i) * 8 +: 8] = byte_done;
              else                         shadow_d[(59 - i) * 8 +: 8] = shadow_q[(59 - i) * 8 +: 8];
            end
            if (byte_cnt_q != CNT_SAT) byte_cnt_d = byte_cnt_q + CNT_W'(1);
            else                       byte_cnt_d = byte_cnt_q;
          end else begin
            byte_cnt_d = byte_cnt_q;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (dibit_cnt_q != 2'd0) begin
          rx_err_d      = 1'b1;
          rx_err_code_d = 2'd2;
        end else if ((byte_cnt_q < CNT_MIN) || (byte_cnt_q > CNT_MAX)) begin
          rx_err_d      = 1'b1;
          rx_err_code_d = 2'd1;
        end else if (crc_q != CRC_RESIDUE) begin
          rx_err_d      = 1'b1;
          rx_err_code_d = 2'd0;
        end else begin
          rx_valid_d = 1'b1;
          pkt_d      = shadow_q;
        end
      end
      ST_DROP: begin
        if (!eth_crsdv) state_d = ST_IDLE;
        else            state_d = ST_DROP;
      end
      default: state_d = ST_IDLE;
    endcase

    rx_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge eth_clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      dibit_cnt_q   <= 2'd0;
      byte_cnt_q    <= '0;
      byte_sr_q     <= 6'd0;
      crc_q         <= CRC_INIT;
      shadow_q      <= '0;
      pkt_q         <= '0;
      rx_valid_q    <= 1'b0;
      rx_err_q      <= 1'b0;
      rx_err_code_q <= 2'd0;
      rx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dibit_cnt_q   <= dibit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_sr_q     <= byte_sr_d;
      crc_q         <= crc_d;
      shadow_q      <= shadow_d;
      pkt_q         <= pkt_d;
      rx_valid_q    <= rx_valid_d;
      rx_err_q      <= rx_err_d;
      rx_err_code_q <= rx_err_code_d;
      rx_busy_q     <= rx_busy_d;
    end
  end

  assign eth_packet  = pkt_q;
  assign rx_valid    = rx_valid_q;
  assign rx_err      = rx_err_q;
  assign rx_err_code = rx_err_code_q;
  assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_eth_rx.sv
// Scoreboard bench for eth_rx: expected frame outcomes are queued as frames are driven,
// and a negedge monitor queues the observed rx_valid/rx_err pulses for comparison.
module tb_eth_rx;

  localparam int MINB = 64;
  localparam int MAXB = 1518;

  logic                eth_clk = 1'b0;
  logic                rst_in;
  logic                eth_crsdv;
  logic [1:0]          eth_rxd;
  Types::st_eth_packet eth_packet;
  logic                rx_valid;
  logic                rx_err;
  logic [1:0]          rx_err_code;
  logic                rx_busy;

  eth_rx #(.MIN_FRAME_BYTES(MINB), .MAX_FRAME_BYTES(MAXB)) dut (
    .eth_clk     (eth_clk),
    .rst_in      (rst_in),
    .eth_crsdv   (eth_crsdv),
    .eth_rxd     (eth_rxd),
    .eth_packet  (eth_packet),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code),
    .rx_busy     (rx_busy)
  );

  always #10 eth_clk = ~eth_clk;

  typedef struct {
    bit           is_err;
    logic [1:0]   code;
    logic [479:0] pkt;
  } ev_t;

  ev_t          exp_q[$];
  ev_t          obs_q[$];
  logic [7:0]   frame_q[$];
  logic [479:0] last_good;
  int           checks = 0;
  int           errors = 0;
  int           both_cnt = 0;

  // Monitor: record each result pulse as it appears.
  always @(negedge eth_clk) begin
    if (rx_valid || rx_err) obs_q.push_back(ev_t'{rx_err, rx_err_code, eth_packet});
    if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
  end

  function automatic logic [31:0] calc_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frame_q[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ frame_q[i][k]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic logic [479:0] pkt_of();
    logic [479:0] p;
    p = '0;
    for (int i = 0; i < 60; i++) if (i < frame_q.size()) p[479 - 8 * i -: 8] = frame_q[i];
    return p;
  endfunction

  task automatic append_fcs();
    logic [31:0] f;
    f = calc_fcs();
    for (int k = 0; k < 4; k++) frame_q.push_back(f[8 * k +: 8]);
  endtask

  task automatic build_hdr();
    logic [47:0] d;
    logic [47:0] s;
    logic [15:0] t;
    d = 48'h1065_3070_3d6d;
    s = 48'h1234_5678_9abc;
    t = 16'h0806;
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(d[47 - 8 * i -: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(s[47 - 8 * i -: 8]);
    frame_q.push_back(t[15:8]);
    frame_q.push_back(t[7:0]);
  endtask

  task automatic build_arp();
    logic [223:0] arp;
    arp = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001, 48'h1234_5678_9abc,
           32'hc0a8_010a, 48'h0, 32'hc0a8_0101};
    build_hdr();
    for (int i = 0; i < 28; i++) frame_q.push_back(arp[223 - 8 * i -: 8]);
    for (int i = 0; i < 18; i++) frame_q.push_back(8'h00);
    append_fcs();
  endtask

  // total counts destination MAC through FCS
  task automatic build_len(input int total);
    build_hdr();
    for (int i = 14; i < total - 4; i++) frame_q.push_back(8'(i) ^ 8'h3c);
    append_fcs();
  endtask

  task automatic drive_dibit(input logic [1:0] d);
    @(negedge eth_clk);
    eth_crsdv = 1'b1;
    eth_rxd   = d;
  endtask

  task automatic drive_preamble(input int bad_pos);
    for (int i = 0; i < 32; i++)
      drive_dibit((i == bad_pos) ? 2'b10 : ((i == 31) ? 2'b11 : 2'b01));
  endtask

  task automatic drive_bytes(input int from, input int to);
    logic [7:0] b;
    for (int i = from; i < to; i++) begin
      b = frame_q[i];
      for (int k = 0; k < 4; k++) drive_dibit(b[2 * k +: 2]);
    end
  endtask

  task automatic end_frame();
    @(negedge eth_clk);
    eth_crsdv = 1'b0;
    eth_rxd   = 2'b00;
  endtask

  task automatic send_frame(input int extra_dibits, input int bad_pos);
    drive_preamble(bad_pos);
    drive_bytes(0, frame_q.size());
    for (int i = 0; i < extra_dibits; i++) drive_dibit(2'b01);
    end_frame();
  endtask

  task automatic wait_obs(input int n, input int budget, output int cycles);
    cycles = 0;
    while (obs_q.size() < n && cycles < budget) begin
      @(negedge eth_clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; eth_crsdv = 1'b0; eth_rxd = 2'b00;
    repeat (3) @(negedge eth_clk);
    #1;
    checks++;
    if (eth_packet !== 480'd0) begin errors++; $display("FAIL reset_packet: got %h want 0", eth_packet); end
    checks++;
    if ({rx_valid, rx_err, rx_err_code, rx_busy} !== 5'd0) begin
      errors++; $display("FAIL reset_flags: got v%b e%b c%0d b%b want all 0", rx_valid, rx_err, rx_err_code, rx_busy);
    end
    @(negedge eth_clk);
    rst_in = 1'b1;
    repeat (2) @(negedge eth_clk);
  endtask

  task automatic test_good_frame();
    int  cyc;
    ev_t e, o;
    build_arp();
    last_good = pkt_of();
    exp_q.push_back(ev_t'{1'b0, 2'd0, last_good});
    send_frame(0, -1);
    wait_obs(1, 40, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL good_latency: got %0d cycles want 2", cyc); end
    repeat (4) @(negedge eth_clk);
    #1;
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL good_count: got %0d pulses want 1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.is_err !== e.is_err || o.code !== e.code) begin
        errors++; $display("FAIL good_kind: got err=%0b code=%0d want err=%0b code=%0d", o.is_err, o.code, e.is_err, e.code);
      end
      checks++;
      if (o.pkt !== e.pkt) begin errors++; $display("FAIL good_pkt: got %h want %h", o.pkt, e.pkt); end
    end
    checks++;
    if (eth_packet.dest_mac !== 48'h1065_3070_3d6d || eth_packet.src_mac !== 48'h1234_5678_9abc ||
        eth_packet.ethertype !== 16'h0806) begin
      errors++; $display("FAIL good_fields: got %h %h %h want 106530703d6d 123456789abc 0806",
                         eth_packet.dest_mac, eth_packet.src_mac, eth_packet.ethertype);
    end
    checks++;
    if (eth_packet.payload[367:320] !== 48'h0001_0800_0604) begin
      errors++; $display("FAIL good_payload_head: got %h want 000108000604", eth_packet.payload[367:320]);
    end
    repeat (20) @(negedge eth_clk);
    #1;
    checks++;
    if (eth_packet !== last_good || rx_busy !== 1'b0) begin
      errors++; $display("FAIL good_hold: got busy=%b pkt %h want busy=0 pkt %h", rx_busy, eth_packet, last_good);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_crc_error();
    int  cyc;
    ev_t e, o;
    build_arp();
    frame_q[30] = frame_q[30] ^ 8'h04;
    exp_q.push_back(ev_t'{1'b1, 2'd0, last_good});
    send_frame(0, -1);
    wait_obs(1, 40, cyc);
    repeat (4) @(negedge eth_clk);
    #1;
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL crc_count: got %0d pulses want 1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.is_err !== e.is_err || o.code !== e.code) begin
        errors++; $display("FAIL crc_kind: got err=%0b code=%0d want err=%0b code=%0d", o.is_err, o.code, e.is_err, e.code);
      end
      checks++;
      if (o.pkt !== e.pkt) begin errors++; $display("FAIL crc_pkt_kept: got %h want %h", o.pkt, e.pkt); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_length();
    int  lens[5];
    int  cyc;
    bit  bad;
    ev_t e, o;
    lens = '{40, 63, 1518, 1519, 1600};
    foreach (lens[j]) begin
      build_len(lens[j]);
      bad = (lens[j] < MINB) || (lens[j] > MAXB);
      if (!bad) last_good = pkt_of();
      exp_q.push_back(ev_t'{bad, bad ? 2'd1 : 2'd0, last_good});
      send_frame(0, -1);
      wait_obs(1, 40, cyc);
      repeat (4) @(negedge eth_clk);
      #1;
      checks++;
      if (obs_q.size() !== 1) begin errors++; $display("FAIL len%0d_count: got %0d pulses want 1", lens[j], obs_q.size()); end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o.is_err !== e.is_err || o.code !== e.code || o.pkt !== e.pkt) begin
          errors++; $display("FAIL len%0d_result: got err=%0b code=%0d pkt %h want err=%0b code=%0d pkt %h",
                             lens[j], o.is_err, o.code, o.pkt, e.is_err, e.code, e.pkt);
        end
      end
      if (lens[j] > MAXB + 1) begin
        checks++;
        if (dut.byte_cnt_q !== 11'(MAXB + 1)) begin
          errors++; $display("FAIL len%0d_saturate: got %0d want %0d", lens[j], dut.byte_cnt_q, MAXB + 1);
        end
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_alignment();
    int  cyc;
    ev_t e, o;
    build_arp();
    exp_q.push_back(ev_t'{1'b1, 2'd2, last_good});
    send_frame(2, -1);
    wait_obs(1, 40, cyc);
    repeat (4) @(negedge eth_clk);
    #1;
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL align_count: got %0d pulses want 1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.is_err !== e.is_err || o.code !== e.code || o.pkt !== e.pkt) begin
        errors++; $display("FAIL align_result: got err=%0b code=%0d want err=%0b code=%0d", o.is_err, o.code, e.is_err, e.code);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_preamble();
    int  cyc;
    ev_t e, o;
    build_arp();
    drive_preamble(10);
    drive_bytes(0, frame_q.size());
    #1;
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %b want 1", rx_busy); end
    end_frame();
    repeat (8) @(negedge eth_clk);
    #1;
    checks++;
    if (obs_q.size() !== 0 || rx_busy !== 1'b0) begin
      errors++; $display("FAIL drop_silent: got %0d pulses busy=%b want 0 pulses busy=0", obs_q.size(), rx_busy);
    end
    build_len(100);
    last_good = pkt_of();
    exp_q.push_back(ev_t'{1'b0, 2'd0, last_good});
    send_frame(0, -1);
    wait_obs(1, 40, cyc);
    #1;
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL after_drop_count: got %0d pulses want 1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.is_err !== e.is_err || o.pkt !== e.pkt) begin
        errors++; $display("FAIL after_drop_result: got err=%0b pkt %h want err=%0b pkt %h", o.is_err, o.pkt, e.is_err, e.pkt);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    int  cyc;
    ev_t e, o;
    build_arp();
    drive_preamble(-1);
    drive_bytes(0, 20);
    #1;
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", rx_busy); end
    @(negedge eth_clk);
    eth_crsdv = 1'b0;
    rst_in    = 1'b0;
    #1;
    checks++;
    if (eth_packet !== 480'd0 || {rx_valid, rx_err, rx_err_code, rx_busy} !== 5'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got pkt %h flags %b want all 0", eth_packet,
                         {rx_valid, rx_err, rx_err_code, rx_busy});
    end
    @(negedge eth_clk);
    rst_in = 1'b1;
    repeat (10) @(negedge eth_clk);
    #1;
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL mid_no_pulse: got %0d pulses want 0", obs_q.size()); end
    build_arp();
    last_good = pkt_of();
    exp_q.push_back(ev_t'{1'b0, 2'd0, last_good});
    send_frame(0, -1);
    wait_obs(1, 40, cyc);
    #1;
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL post_reset_count: got %0d pulses want 1", obs_q.size()); end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.is_err !== e.is_err || o.pkt !== e.pkt) begin
        errors++; $display("FAIL post_reset_result: got err=%0b pkt %h want err=%0b pkt %h", o.is_err, o.pkt, e.is_err, e.pkt);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // Second preamble starts in the CHECK cycle of the first frame.
  task automatic test_back_to_back();
    int  cyc;
    ev_t e, o;
    build_len(80);
    exp_q.push_back(ev_t'{1'b0, 2'd0, pkt_of()});
    send_frame(0, -1);
    build_arp();
    last_good = pkt_of();
    exp_q.push_back(ev_t'{1'b0, 2'd0, last_good});
    send_frame(0, -1);
    wait_obs(2, 40, cyc);
    repeat (4) @(negedge eth_clk);
    #1;
    checks++;
    if (obs_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d pulses want 2", obs_q.size()); end
    for (int i = 0; i < 2; i++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++;
        if (o.is_err !== e.is_err || o.pkt !== e.pkt) begin
          errors++; $display("FAIL b2b_frame%0d: got err=%0b pkt %h want err=%0b pkt %h", i, o.is_err, o.pkt, e.is_err, e.pkt);
        end
      end
    end
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_length();
    test_alignment();
    test_bad_preamble();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 80000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
